// File: rtl/axi4_pkg.sv
// Shared AXI4 read-path types and the per-beat burst address arithmetic.
package axi4_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10
   } burst_e;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } rd_state_e;

   // WRAP keeps the bits above the wrap window and lets the low bits roll over.
   function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                             input logic [7:0]  len,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
      logic [63:0] step;
      logic [63:0] wrap_mask;
      logic [63:0] incr;
      step      = 64'd1 << size;
      wrap_mask = ((64'(len) + 64'd1) << size) - 64'd1;
      incr      = addr + step;
      case (burst)
         FIXED:   next_addr = addr;
         WRAP:    next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
         default: next_addr = incr;
      endcase
   endfunction

endpackage

// File: rtl/axi4_rd_resp_fifo.sv
// Two-entry response buffer between the SRAM return and the R channel.
module axi4_rd_resp_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

endmodule

// File: rtl/axi4_slave_rd_sram.sv
// AXI4 read responder: one burst at a time, one SRAM read per beat, R beats via a 2-entry buffer.
module axi4_slave_rd_sram
   import axi4_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ID_W      = 4,
   parameter int unsigned       MEM_AW    = 14,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1c00_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   ARID,
   input  logic [ADDR_W-1:0] ARADDR,
   input  logic [7:0]        ARLEN,
   input  logic [2:0]        ARSIZE,
   input  logic [1:0]        ARBURST,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [ID_W-1:0]   RID,
   output logic [DATA_W-1:0] RDATA,
   output logic [1:0]        RRESP,
   output logic              RLAST,
   output logic              RVALID,
   input  logic              RREADY,
   output logic              sram_en,
   output logic [MEM_AW-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_rdata
);

   localparam int unsigned LOG2_BYTES  = $clog2(DATA_W / 8);
   localparam int unsigned RANGE_SHIFT = MEM_AW + LOG2_BYTES;
   localparam int unsigned FW          = DATA_W + 3;

   rd_state_e         state_q, state_d;
   logic [ID_W-1:0]   id_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        len_q;
   logic [7:0]        beat_cnt;
   logic [2:0]        size_q;
   logic [1:0]        burst_q;
   resp_e             resp_q;
   resp_e             ar_resp;
   logic              inflight;
   logic              inflight_last;
   logic              ready_ok;
   logic              accept;
   logic              issue;
   logic              pop;
   logic              push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [1:0]        fifo_count;
   logic [2:0]        occupancy;
   logic [DATA_W-1:0] beat_data;
   logic [FW-1:0]     fifo_wdata;
   logic [FW-1:0]     fifo_rdata;
   logic [ADDR_W-1:0] ar_off;
   logic              ar_decerr;
   logic              ar_slverr;

   assign ARREADY = (state_q == IDLE) && ready_ok;
   assign accept  = ARVALID && ARREADY;
   assign RVALID  = !fifo_empty;
   assign pop     = RVALID && RREADY;
   assign push    = inflight;
   // A pop in the same cycle frees a slot, which keeps the bus at one beat per cycle.
   assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);

   assign ar_off    = ARADDR - BASE_ADDR;
   assign ar_decerr = (ARADDR < BASE_ADDR) || ((ar_off >> RANGE_SHIFT) != '0);
   assign ar_slverr = (ARSIZE > 3'(LOG2_BYTES)) || (ARBURST == 2'b11) ||
                      ((ARBURST == WRAP) && !(ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));
   assign ar_resp   = ar_decerr ? DECERR : (ar_slverr ? SLVERR : OKAY);

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = ISSUE;
         end
         ISSUE: begin
            if (occupancy < 3'd2) begin
               issue = 1'b1;
               if (beat_cnt == len_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && RLAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ready_ok      <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         beat_cnt      <= '0;
         id_q          <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         size_q        <= '0;
         burst_q       <= '0;
         resp_q        <= OKAY;
      end else begin
         state_q       <= state_d;
         ready_ok      <= 1'b1;
         inflight      <= issue;
         inflight_last <= issue && (beat_cnt == len_q);
         if (accept) begin
            id_q     <= ARID;
            addr_q   <= ARADDR;
            len_q    <= ARLEN;
            size_q   <= ARSIZE;
            burst_q  <= ARBURST;
            resp_q   <= ar_resp;
            beat_cnt <= '0;
         end else if (issue && (beat_cnt != len_q)) begin
            beat_cnt <= beat_cnt + 8'd1;
            addr_q   <= ADDR_W'(next_addr(64'(addr_q), len_q, size_q, burst_q));
         end
      end
   end

   // Error bursts still walk every beat through the buffer, just without touching the SRAM.
   assign sram_en   = issue && (resp_q == OKAY);
   assign sram_addr = MEM_AW'((addr_q - BASE_ADDR) >> LOG2_BYTES);

   assign beat_data  = (resp_q == OKAY) ? sram_rdata : '0;
   assign fifo_wdata = {beat_data, resp_q, inflight_last};

   axi4_rd_resp_fifo #(
      .WIDTH(FW)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .wdata(fifo_wdata),
      .rdata(fifo_rdata),
      .full (fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
   );

   assign RID   = id_q;
   assign RDATA = fifo_rdata[FW-1:3];
   assign RRESP = fifo_rdata[2:1];
   assign RLAST = fifo_rdata[0];

   assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_axi4_slave_rd_sram.sv
// Directed bench for axi4_slave_rd_sram: vector table of bursts plus reset/latency sequences.
module tb_axi4_slave_rd_sram;

   localparam logic [31:0] BASE = 32'h1c00_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;
   logic        sram_en;
   logic [13:0] sram_addr;
   logic [31:0] sram_rdata;

   logic [31:0] mem [0:16383];

   int n_tests = 0;
   int n_fail  = 0;
   int en_cnt  = 0;
   int issued  = 0;
   int popped  = 0;
   int max_ahead = 0;

   axi4_slave_rd_sram #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .ID_W     (4),
      .MEM_AW   (14),
      .BASE_ADDR(32'h1c00_0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ARID      (ARID),
      .ARADDR    (ARADDR),
      .ARLEN     (ARLEN),
      .ARSIZE    (ARSIZE),
      .ARBURST   (ARBURST),
      .ARVALID   (ARVALID),
      .ARREADY   (ARREADY),
      .RID       (RID),
      .RDATA     (RDATA),
      .RRESP     (RRESP),
      .RLAST     (RLAST),
      .RVALID    (RVALID),
      .RREADY    (RREADY),
      .sram_en   (sram_en),
      .sram_addr (sram_addr),
      .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous SRAM model: data valid the cycle after sram_en.
   always @(posedge clk) begin
      if (sram_en) sram_rdata <= mem[sram_addr];
   end

   // Outstanding reads = SRAM reads issued minus OKAY beats popped.
   always @(posedge clk) begin
      if (rst) begin
         issued = 0;
         popped = 0;
      end else begin
         if (sram_en) begin
            issued = issued + 1;
            en_cnt = en_cnt + 1;
         end
         if (RVALID && RREADY && RRESP == 2'b00) popped = popped + 1;
         if (issued - popped > max_ahead) max_ahead = issued - popped;
      end
   end

   function automatic logic [31:0] word_val(input int i);
      word_val = (i == 4) ? 32'hDEAD_BEEF : (32'h5A00_0000 | 32'(i));
   endfunction

   function automatic logic [111:0] wl(input int a, input int b = 0, input int c = 0,
                                       input int d = 0, input int e = 0, input int f = 0,
                                       input int g = 0, input int h = 0);
      wl = {14'(h), 14'(g), 14'(f), 14'(e), 14'(d), 14'(c), 14'(b), 14'(a)};
   endfunction

   typedef struct {
      logic [3:0]   id;
      logic [31:0]  addr;
      logic [7:0]   len;
      logic [2:0]   size;
      logic [1:0]   burst;
      logic [3:0]   rr_pat;
      logic [1:0]   resp;
      logic [111:0] words;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_burst(input int vi, input vec_t v);
      int   beats;
      int   got;
      int   cyc;
      int   ph;
      int   en_start;
      logic stalled;
      logic saw_ready;
      logic [39:0] held;
      logic [31:0] exp_data;
      beats = int'(v.len) + 1;
      ARID    = v.id;
      ARADDR  = v.addr;
      ARLEN   = v.len;
      ARSIZE  = v.size;
      ARBURST = v.burst;
      ARVALID = 1'b1;
      RREADY  = 1'b0;
      cyc = 0;
      while (!ARREADY && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check($sformatf("v%0d_arready_idle", vi), ARREADY, 1);
      en_start = en_cnt;
      @(posedge clk); #1;
      ARVALID = 1'b0;
      check($sformatf("v%0d_sram_en_t1", vi), sram_en, (v.resp == 2'b00) ? 1 : 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_rvalid_t1", vi), RVALID, 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_rvalid_t2", vi), RVALID, 1);
      got = 0; cyc = 0; ph = 0;
      stalled = 1'b0; saw_ready = 1'b0; held = '0;
      while (got < beats && cyc < 300) begin
         RREADY = v.rr_pat[ph % 4];
         ph++;
         if (stalled)
            check($sformatf("v%0d_stall_hold", vi), {RVALID, RDATA, RRESP, RLAST, RID}, held);
         if (ARREADY) saw_ready = 1'b1;
         if (RVALID && RREADY) begin
            exp_data = (v.resp == 2'b00) ? word_val(int'(v.words[got*14 +: 14])) : 32'h0;
            check($sformatf("v%0d_b%0d_data", vi, got), RDATA, exp_data);
            check($sformatf("v%0d_b%0d_id", vi, got), RID, v.id);
            check($sformatf("v%0d_b%0d_resp", vi, got), RRESP, v.resp);
            check($sformatf("v%0d_b%0d_last", vi, got), RLAST, (got == beats - 1) ? 1 : 0);
            got++;
         end
         stalled = RVALID && !RREADY;
         held    = {RVALID, RDATA, RRESP, RLAST, RID};
         @(posedge clk); #1;
         cyc++;
      end
      RREADY = 1'b0;
      check($sformatf("v%0d_beat_count", vi), got, beats);
      check($sformatf("v%0d_arready_busy", vi), saw_ready, 0);
      check($sformatf("v%0d_arready_after", vi), ARREADY, 1);
      check($sformatf("v%0d_no_extra", vi), RVALID, 0);
      check($sformatf("v%0d_sram_reads", vi), en_cnt - en_start, (v.resp == 2'b00) ? beats : 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      for (int i = 0; i < 16384; i++) mem[i] = word_val(i);
      sram_rdata = 32'h0;
      rst = 1'b1; ARVALID = 1'b0; RREADY = 1'b0;
      ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;

      //           id     addr           len   sz    burst  rr     resp   words
      vecs[0]  = '{4'd3, BASE + 32'h10,    8'd0, 3'd2, 2'b01, 4'hF, 2'b00, wl(4)};
      vecs[1]  = '{4'd5, BASE + 32'h20,    8'd3, 3'd2, 2'b01, 4'hF, 2'b00, wl(8, 9, 10, 11)};
      vecs[2]  = '{4'd1, BASE + 32'h38,    8'd3, 3'd2, 2'b10, 4'hF, 2'b00, wl(14, 15, 12, 13)};
      vecs[3]  = '{4'd2, BASE + 32'h38,    8'd2, 3'd2, 2'b10, 4'hF, 2'b10, wl(0)};
      vecs[4]  = '{4'd9, BASE + 32'h100,   8'd7, 3'd2, 2'b01, 4'b1001, 2'b00,
                   wl(64, 65, 66, 67, 68, 69, 70, 71)};
      vecs[5]  = '{4'd6, BASE - 32'h4,     8'd1, 3'd2, 2'b01, 4'hF, 2'b11, wl(0)};
      vecs[6]  = '{4'd4, BASE + 32'h40,    8'd2, 3'd2, 2'b00, 4'hF, 2'b00, wl(16, 16, 16)};
      vecs[7]  = '{4'd7, BASE + 32'h40,    8'd0, 3'd3, 2'b01, 4'hF, 2'b10, wl(0)};
      vecs[8]  = '{4'd8, BASE + 32'h40,    8'd1, 3'd2, 2'b11, 4'hF, 2'b10, wl(0)};
      vecs[9]  = '{4'hA, BASE + 32'h10000, 8'd0, 3'd2, 2'b01, 4'hF, 2'b11, wl(0)};
      vecs[10] = '{4'hB, BASE + 32'hFFFC,  8'd0, 3'd2, 2'b01, 4'hF, 2'b00, wl(16383)};
      vecs[11] = '{4'hC, BASE + 32'h2,     8'd3, 3'd1, 2'b01, 4'b0101, 2'b00, wl(0, 1, 1, 2)};
      vecs[12] = '{4'hD, BASE + 32'h4C,    8'd1, 3'd2, 2'b10, 4'hF, 2'b00, wl(19, 18)};

      repeat (3) @(posedge clk);
      #1;
      check("rst_arready", ARREADY, 0);
      check("rst_rvalid", RVALID, 0);
      check("rst_rlast", RLAST, 0);
      check("rst_rresp", RRESP, 0);
      check("rst_rid", RID, 0);
      check("rst_rdata", RDATA, 0);
      check("rst_sram_en", sram_en, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_arready", ARREADY, 1);

      for (int i = 0; i < 13; i++) run_burst(i, vecs[i]);
      check("max_reads_ahead_ok", (max_ahead <= 2) ? 1 : 0, 1);

      // Reset while beat 2 of an 8-beat burst is waiting on the bus.
      ARID = 4'd7; ARADDR = BASE + 32'h200; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = 2'b01;
      ARVALID = 1'b1;
      cyc = 0;
      while (!ARREADY && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      @(posedge clk); #1;
      ARVALID = 1'b0;
      RREADY  = 1'b1;
      cyc = 0;
      while (!(RVALID && RREADY) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("mr_beat1_data", RDATA, word_val(128));
      @(posedge clk); #1;
      RREADY = 1'b0;
      check("mr_beat2_pending", RVALID, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mr_rvalid_dropped", RVALID, 0);
      check("mr_arready_low", ARREADY, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mr_arready_back", ARREADY, 1);
      check("mr_no_stale", RVALID, 0);
      run_burst(99, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
